rf_seq_fsm: RTL and testbench
=============================

Name: rf_seq_fsm

Overview:
Moore control FSM that sequences the 8x16 register file and its datapath (A/B/C/status registers, shifter, ALU) for one instruction at a time. It latches the 16-bit instruction on start, drives readnum/writenum/write and the datapath load and select strobes state by state, then raises w when idle. It sits between the instruction register and the datapath.

Parameters:
INSTR_W, 16, instruction width; field positions fixed: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0], imm8[7:0]
REG_ADDR_W, 3, register index width for readnum and writenum

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
s  input  1  start; sampled only in WAIT
instr  input  INSTR_W  instruction; latched into an internal register on accepted start
w  output  1  idle/ready; high only in WAIT
readnum  output  REG_ADDR_W  register file read index
writenum  output  REG_ADDR_W  register file write index
write  output  1  register file write enable
loada, loadb, loadc, loads  output  1 each  datapath A/B/C/status register load enables
asel  output  1  1 forces the A operand to 0
vsel  output  2  writeback source: 00 = C result, 01 = sign-extended imm8, 1x reserved (never driven)
aluop  output  2  ALU operation: 00 add, 01 sub, 10 and, 11 not-B
illegal  output  1  undefined opcode/op was decoded

Behaviour:
- Reset is asynchronous and active-low. On reset: state WAIT, latched instruction 0, w=1, illegal=0, every other output 0. Reset asserted mid-instruction aborts it; no write or load occurs after reset asserts.
- All outputs are a pure function of state and the latched instruction. No output depends combinationally on s or instr.
- WAIT: w=1. s=1 at an edge latches instr and moves to DECODE. s is ignored in every other state; holding s high re-triggers only after WAIT is re-entered.
- DECODE: all strobes 0. Next state depends on the latched instruction:
  - 110/10 (MOV Rn,#imm8) goes to WRITE_IMM.
  - 110/00 (MOV Rd,Rm{,sh}) and 101/11 (MVN) go to GET_B.
  - 101/00 (ADD), 101/01 (CMP) and 101/10 (AND) go to GET_A.
  - Anything else is illegal (see Optional Feature).
- WRITE_IMM: writenum=Rn, vsel=01, write=1, then WAIT.
- GET_A: readnum=Rn, loada=1, then GET_B.
- GET_B: readnum=Rm, loadb=1, then ALU.
- ALU: aluop = op for opcode 101; for MOV-reg, aluop=00 and asel=1. loadc=1, except CMP, which asserts loads=1 and loadc=0. CMP then goes to WAIT; all others go to WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=00, write=1, then WAIT.
- Each strobe is high for exactly one cycle per instruction.
- readnum holds its last value outside GET_A/GET_B. writenum is Rn or Rd only while write=1, 0 otherwise.
- Latency, counted in edges from the start-accept edge until w=1:
  - MOV imm: 2
  - MOV reg / MVN: 4
  - CMP: 4
  - ADD / AND: 5

Optional Feature:
Macro RF_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal decode moves to HALT. In HALT, illegal=1, w=0 and all strobes are 0. HALT is left only by reset.
- Undefined: an illegal decode returns to WAIT on the next edge with no strobes. illegal pulses high for the single DECODE cycle.

Decomposition:
- Package rf_seq_pkg holds:
  - state enum: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, HALT
  - opcode/op localparams
  - vsel and aluop encodings
  - instruction field-slice constants
- One sub-module, rf_seq_decode: combinational classification of the latched instruction into instruction class and illegal flag.
- The FSM register and output decode live in rf_seq_fsm.

Test Plan:
1. Reset low mid-GET_B of an ADD, then release: all strobes 0 immediately, w=1. No write observed afterwards.
2. s=1 with instr=16'hD041 (MOV R0,#65): write=1 with writenum=0 and vsel=01 exactly 2 edges after start; w=1 one cycle later. Regfile readback of R0 = 65.
3. With R0=45 and R1=100 preloaded, ADD R2,R1,R0 (16'hA140): GET_A readnum=1, GET_B readnum=0, loadc pulse, then write with writenum=2 and vsel=00. Five edges total; R2 reads back 145.
4. CMP R1,R0 (16'hA900): loads=1 exactly once, write never asserted, w=1 after 4 edges.
5. MVN R3,R0 (16'hB860): no loada pulse, aluop=11 in ALU, write with writenum=3. s held high throughout: a second run starts only after w=1.
6. instr=16'hE000 (opcode 111):
   - Macro defined: illegal=1 and w=0 held until reset.
   - Macro undefined: illegal pulses for one cycle, and w=1 two edges after start.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared types and encodings for the register-file sequencer: states, instruction
// classes, opcode/op values, field positions and datapath select encodings.
package rf_seq_pkg;

   typedef enum logic [2:0] {
      WAIT,
      DECODE,
      WRITE_IMM,
      GET_A,
      GET_B,
      ALU,
      WRITE_REG,
      HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_MOV_IMM,
      CLS_MOV_REG,
      CLS_MVN,
      CLS_ADD,
      CLS_CMP,
      CLS_AND,
      CLS_ILLEGAL
   } instr_class_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b01;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   localparam int OPCODE_LSB = 13;
   localparam int OP_LSB     = 11;
   localparam int RN_LSB     = 8;
   localparam int RD_LSB     = 5;
   localparam int SH_LSB     = 3;
   localparam int RM_LSB     = 0;

endpackage

// File: rtl/rf_seq_decode.sv
// Combinational classification of the latched opcode/op pair into an instruction
// class, flagging every combination the sequencer does not implement.
module rf_seq_decode
   import rf_seq_pkg::*;
(
   input  logic [2:0]   opcode,
   input  logic [1:0]   op,
   output instr_class_t iclass,
   output logic         illegal
);

   always_comb begin
      iclass = CLS_ILLEGAL;
      case (opcode)
         OPC_MOV: begin
            if (op == OP_MOV_IMM)      iclass = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) iclass = CLS_MOV_REG;
         end
         OPC_ALU: begin
            case (op)
               OP_ADD:  iclass = CLS_ADD;
               OP_CMP:  iclass = CLS_CMP;
               OP_AND:  iclass = CLS_AND;
               default: iclass = CLS_MVN;
            endcase
         end
         default: iclass = CLS_ILLEGAL;
      endcase
      illegal = (iclass == CLS_ILLEGAL);
   end

endmodule

// File: rtl/rf_seq_fsm.sv
// Moore control FSM sequencing the 8x16 register file and datapath one instruction
// at a time. Define RF_SEQ_ILLEGAL_TRAP_EN to trap illegal decodes in HALT until reset.
module rf_seq_fsm
   import rf_seq_pkg::*;
#(
   parameter int INSTR_W    = 16,
   parameter int REG_ADDR_W = 3
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  s,
   input  logic [INSTR_W-1:0]    instr,
   output logic                  w,
   output logic [REG_ADDR_W-1:0] readnum,
   output logic [REG_ADDR_W-1:0] writenum,
   output logic                  write,
   output logic                  loada,
   output logic                  loadb,
   output logic                  loadc,
   output logic                  loads,
   output logic                  asel,
   output logic [1:0]            vsel,
   output logic [1:0]            aluop,
   output logic                  illegal
);

   state_t                  state, next_state;
   logic [INSTR_W-1:0]      ir;
   logic [REG_ADDR_W-1:0]   readnum_q;
   instr_class_t            iclass;
   logic                    dec_illegal;
   logic [REG_ADDR_W-1:0]   rn, rd, rm;
   logic [1:0]              op;
   logic                    unused_shift;

   assign rn = ir[RN_LSB +: REG_ADDR_W];
   assign rd = ir[RD_LSB +: REG_ADDR_W];
   assign rm = ir[RM_LSB +: REG_ADDR_W];
   assign op = ir[OP_LSB +: 2];
   // The shift field is consumed by the datapath's shifter, not by the sequencer.
   assign unused_shift = ^ir[SH_LSB +: 2];

   rf_seq_decode u_decode (
      .opcode  (ir[OPCODE_LSB +: 3]),
      .op      (op),
      .iclass  (iclass),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= WAIT;
         ir        <= '0;
         readnum_q <= '0;
      end else begin
         state     <= next_state;
         readnum_q <= readnum;
         if (state == WAIT && s) ir <= instr;
      end
   end

   // readnum is registered so it keeps the last read index outside the fetch states.
   always_comb begin
      next_state = state;
      w          = 1'b0;
      readnum    = readnum_q;
      writenum   = '0;
      write      = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      vsel       = VSEL_C;
      aluop      = ALU_ADD;
      illegal    = 1'b0;
      case (state)
         WAIT: begin
            w = 1'b1;
            if (s) next_state = DECODE;
         end
         DECODE: begin
            case (iclass)
               CLS_MOV_IMM:                   next_state = WRITE_IMM;
               CLS_MOV_REG, CLS_MVN:          next_state = GET_B;
               CLS_ADD, CLS_CMP, CLS_AND:     next_state = GET_A;
               default: begin
                  illegal = dec_illegal;
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
                  next_state = HALT;
`else
                  next_state = WAIT;
`endif
               end
            endcase
         end
         WRITE_IMM: begin
            writenum   = rn;
            vsel       = VSEL_IMM;
            write      = 1'b1;
            next_state = WAIT;
         end
         GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            next_state = GET_B;
         end
         GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            next_state = ALU;
         end
         ALU: begin
            if (iclass == CLS_MOV_REG) begin
               asel  = 1'b1;
               aluop = ALU_ADD;
            end else begin
               aluop = op;
            end
            if (iclass == CLS_CMP) begin
               loads      = 1'b1;
               next_state = WAIT;
            end else begin
               loadc      = 1'b1;
               next_state = WRITE_REG;
            end
         end
         WRITE_REG: begin
            writenum   = rd;
            vsel       = VSEL_C;
            write      = 1'b1;
            next_state = WAIT;
         end
         HALT: begin
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
            illegal = 1'b1;
`else
            next_state = WAIT;
`endif
         end
         default: next_state = WAIT;
      endcase
   end

endmodule

// File: tb/tb_rf_seq_fsm.sv
// Self-checking bench for rf_seq_fsm: a behavioural datapath executes the strobes and
// an architectural model of the instruction set predicts registers, flag and timing.
module tb_rf_seq_fsm;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        s = 1'b0;
   logic [15:0] instr = 16'h0;
   logic        w, write, loada, loadb, loadc, loads, asel, illegal;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, aluop;

   int checks = 0;
   int errors = 0;

   rf_seq_fsm #(.INSTR_W(16), .REG_ADDR_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .s(s), .instr(instr), .w(w),
      .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .vsel(vsel), .aluop(aluop), .illegal(illegal)
   );

   always #5 clk = ~clk;

   wire [12:0] strobes = {write, loada, loadb, loadc, loads, asel, vsel, aluop, writenum};

   // Behavioural datapath: register file, A/B/C/status, shifter and ALU.
   logic [15:0] cur_ins = 16'h0;
   logic [15:0] dreg [8];
   logic [15:0] ra, rb, rc, dp_ain, dp_res;
   logic        dz;
   int          wr_total = 0;

   function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
      case (sh)
         2'b00:   return v;
         2'b01:   return v << 1;
         2'b10:   return v >> 1;
         default: return {v[15], v[15:1]};
      endcase
   endfunction

   always @(posedge clk) begin
      dp_ain = asel ? 16'h0 : ra;
      case (aluop)
         2'b00:   dp_res = dp_ain + shf(rb, cur_ins[4:3]);
         2'b01:   dp_res = dp_ain - shf(rb, cur_ins[4:3]);
         2'b10:   dp_res = dp_ain & shf(rb, cur_ins[4:3]);
         default: dp_res = ~shf(rb, cur_ins[4:3]);
      endcase
      if (write) begin
         dreg[writenum] <= (vsel == 2'b01) ? {{8{cur_ins[7]}}, cur_ins[7:0]} : rc;
         wr_total = wr_total + 1;
      end
      if (loada) ra <= dreg[readnum];
      if (loadb) rb <= dreg[readnum];
      if (loadc) rc <= dp_res;
      if (loads) dz <= (dp_res == 16'h0);
   end

   // Architectural reference model.
   logic [15:0] mreg [8];
   logic        mz;

   task automatic model_apply(input logic [15:0] ins);
      logic [15:0] b, t;
      b = shf(mreg[ins[2:0]], ins[4:3]);
      case (ins[15:11])
         5'b11010: mreg[ins[10:8]] = {{8{ins[7]}}, ins[7:0]};
         5'b11000: mreg[ins[7:5]]  = b;
         5'b10111: mreg[ins[7:5]]  = ~b;
         5'b10100: mreg[ins[7:5]]  = mreg[ins[10:8]] + b;
         5'b10110: mreg[ins[7:5]]  = mreg[ins[10:8]] & b;
         5'b10101: begin
            t  = mreg[ins[10:8]] - b;
            mz = (t == 16'h0);
         end
         default: ;
      endcase
   endtask

   function automatic int exp_lat(input logic [15:0] ins);
      case (ins[15:11])
         5'b11010:                     return 2;
         5'b11000, 5'b10111, 5'b10101: return 4;
         5'b10100, 5'b10110:           return 5;
         default:                      return 1;
      endcase
   endfunction

   // Per-instruction observations; lat stays -1 if w never returns within the bound.
   int          lat, write_at, n_write, n_loada, n_loadb, n_loadc, n_loads, n_illegal;
   logic [2:0]  wnum, rnum_a, rnum_b;
   logic [1:0]  vsel_seen, alu_seen;
   logic        asel_seen;

   task automatic start_instr(input logic [15:0] ins, input bit hold);
      @(negedge clk);
      instr   = ins;
      cur_ins = ins;
      s       = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) s = 1'b0;
   endtask

   task automatic monitor();
      int edges;
      edges = 0;
      lat = -1; write_at = -1;
      n_write = 0; n_loada = 0; n_loadb = 0; n_loadc = 0; n_loads = 0; n_illegal = 0;
      wnum = 3'd0; rnum_a = 3'd0; rnum_b = 3'd0; vsel_seen = 2'b00; alu_seen = 2'b00;
      asel_seen = 1'b0;
      while (edges < 20) begin
         @(negedge clk);
         if (w) begin
            lat = edges;
            break;
         end
         if (write) begin n_write++; wnum = writenum; vsel_seen = vsel; write_at = edges; end
         if (loada) begin n_loada++; rnum_a = readnum; end
         if (loadb) begin n_loadb++; rnum_b = readnum; end
         if (loadc || loads) begin alu_seen = aluop; asel_seen = asel; end
         n_loadc   += int'(loadc);
         n_loads   += int'(loads);
         n_illegal += int'(illegal);
         edges++;
      end
   endtask

   task automatic run_model(input logic [15:0] ins);
      start_instr(ins, 1'b0);
      monitor();
      model_apply(ins);
   endtask

   task automatic test_reset();
      int wr0;
      repeat (2) @(negedge clk);
      checks++;
      if (w !== 1'b1 || illegal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_w_illegal got w=%b illegal=%b want w=1 illegal=0", w, illegal);
      end
      checks++;
      if (strobes !== 13'h0 || readnum !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_strobes got %h readnum=%0d want 0 0", strobes, readnum);
      end
      reset_n = 1'b1;
      start_instr(16'hA140, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (loadb !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_in_get_b got loadb=%b want 1", loadb);
      end
      wr0 = wr_total;
      reset_n = 1'b0;
      #1;
      checks++;
      if (w !== 1'b1 || strobes !== 13'h0) begin
         errors++;
         $display("[TB] FAIL abort_immediate got w=%b strobes=%h want w=1 strobes=0", w, strobes);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (wr_total !== wr0 || w !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_no_write got writes=%0d w=%b want writes=%0d w=1", wr_total, w, wr0);
      end
   endtask

   task automatic test_idle_inputs();
      @(negedge clk);
      instr = 16'hA140;
      @(negedge clk);
      instr = 16'hD0FF;
      #1;
      checks++;
      if (w !== 1'b1 || strobes !== 13'h0) begin
         errors++;
         $display("[TB] FAIL idle_instr_no_start got w=%b strobes=%h want w=1 strobes=0", w, strobes);
      end
   endtask

   task automatic test_mov_imm();
      run_model(16'hD041);
      checks++;
      if (lat !== 2) begin errors++; $display("[TB] FAIL mov_imm_latency got %0d want 2", lat); end
      // write_at counts edges after the accept edge, so 1 here is the second edge overall.
      checks++;
      if (n_write !== 1 || write_at !== 1 || wnum !== 3'd0 || vsel_seen !== 2'b01) begin
         errors++;
         $display("[TB] FAIL mov_imm_write got n=%0d at=%0d wnum=%0d vsel=%b want 1 1 0 01",
                  n_write, write_at, wnum, vsel_seen);
      end
      checks++;
      if (dreg[0] !== 16'd65) begin errors++; $display("[TB] FAIL mov_imm_r0 got %0d want 65", dreg[0]); end
   endtask

   task automatic test_add();
      run_model(16'hD02D);
      run_model(16'hD164);
      run_model(16'hA140);
      checks++;
      if (lat !== 5) begin errors++; $display("[TB] FAIL add_latency got %0d want 5", lat); end
      checks++;
      if (rnum_a !== 3'd1 || rnum_b !== 3'd0 || n_loadc !== 1 || n_loads !== 0) begin
         errors++;
         $display("[TB] FAIL add_reads got a=%0d b=%0d loadc=%0d loads=%0d want 1 0 1 0",
                  rnum_a, rnum_b, n_loadc, n_loads);
      end
      checks++;
      if (n_write !== 1 || wnum !== 3'd2 || vsel_seen !== 2'b00 || alu_seen !== 2'b00) begin
         errors++;
         $display("[TB] FAIL add_write got n=%0d wnum=%0d vsel=%b aluop=%b want 1 2 00 00",
                  n_write, wnum, vsel_seen, alu_seen);
      end
      checks++;
      if (dreg[2] !== 16'd145 || mreg[2] !== 16'd145) begin
         errors++;
         $display("[TB] FAIL add_r2 got %0d want 145", dreg[2]);
      end
   endtask

   task automatic test_cmp();
      run_model(16'hA900);
      checks++;
      if (lat !== 4) begin errors++; $display("[TB] FAIL cmp_latency got %0d want 4", lat); end
      checks++;
      if (n_loads !== 1 || n_loadc !== 0 || n_write !== 0 || alu_seen !== 2'b01) begin
         errors++;
         $display("[TB] FAIL cmp_strobes got loads=%0d loadc=%0d write=%0d aluop=%b want 1 0 0 01",
                  n_loads, n_loadc, n_write, alu_seen);
      end
      checks++;
      if (dz !== mz) begin errors++; $display("[TB] FAIL cmp_flag got %b want %b", dz, mz); end
   endtask

   task automatic test_mvn_hold();
      start_instr(16'hB860, 1'b1);
      monitor();
      model_apply(16'hB860);
      checks++;
      if (lat !== 4 || n_loada !== 0 || alu_seen !== 2'b11 || asel_seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mvn_run got lat=%0d loada=%0d aluop=%b asel=%b want 4 0 11 0",
                  lat, n_loada, alu_seen, asel_seen);
      end
      checks++;
      if (n_write !== 1 || wnum !== 3'd3 || dreg[3] !== ~16'd45) begin
         errors++;
         $display("[TB] FAIL mvn_write got n=%0d wnum=%0d r3=%h want 1 3 %h", n_write, wnum, dreg[3], ~16'd45);
      end
      @(posedge clk);
      #1;
      checks++;
      if (w !== 1'b0) begin errors++; $display("[TB] FAIL hold_retrigger got w=%b want 0", w); end
      s = 1'b0;
      monitor();
      model_apply(16'hB860);
      checks++;
      if (lat !== 4 || dreg[3] !== mreg[3]) begin
         errors++;
         $display("[TB] FAIL hold_second_run got lat=%0d r3=%h want 4 %h", lat, dreg[3], mreg[3]);
      end
   endtask

   task automatic test_random();
      logic [15:0] ins;
      logic [2:0]  rn, rd, rm, exp_rnum;
      logic [1:0]  sh;
      logic [7:0]  imm;
      int          cls, bad;
      for (int r = 0; r < 8; r++) run_model({5'b11010, 3'(r), 8'($urandom)});
      exp_rnum = readnum;
      for (int it = 0; it < 40; it++) begin
         cls = int'($urandom_range(0, 5));
         rn  = 3'($urandom_range(0, 7));
         rd  = 3'($urandom_range(0, 7));
         rm  = 3'($urandom_range(0, 7));
         sh  = 2'($urandom_range(0, 3));
         imm = 8'($urandom);
         if (cls == 4 && $urandom_range(0, 2) == 0) begin rm = rn; sh = 2'b00; end
         case (cls)
            0:       ins = {5'b11010, rn, imm};
            1:       ins = {5'b11000, 3'd0, rd, sh, rm};
            2:       ins = {5'b10111, 3'd0, rd, sh, rm};
            3:       ins = {5'b10100, rn, rd, sh, rm};
            4:       ins = {5'b10101, rn, 3'd0, sh, rm};
            default: ins = {5'b10110, rn, rd, sh, rm};
         endcase
         run_model(ins);
         if (cls != 0) exp_rnum = rm;
         checks++;
         if (lat !== exp_lat(ins)) begin
            errors++;
            $display("[TB] FAIL rand_latency ins=%h got %0d want %0d", ins, lat, exp_lat(ins));
         end
         checks++;
         if (n_write !== int'(cls != 4) || n_loada !== int'(cls >= 3) || n_loads !== int'(cls == 4)
             || n_loadb !== int'(cls != 0) || n_illegal !== 0) begin
            errors++;
            $display("[TB] FAIL rand_strobes ins=%h got wr=%0d la=%0d lb=%0d ls=%0d il=%0d",
                     ins, n_write, n_loada, n_loadb, n_loads, n_illegal);
         end
         checks++;
         if (readnum !== exp_rnum) begin
            errors++;
            $display("[TB] FAIL rand_readnum_hold ins=%h got %0d want %0d", ins, readnum, exp_rnum);
         end
         bad = 0;
         for (int r = 0; r < 8; r++) if (dreg[r] !== mreg[r]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rand_regfile ins=%h got %0d wrong registers want 0", ins, bad);
         end
         if (cls == 4) begin
            checks++;
            if (dz !== mz) begin errors++; $display("[TB] FAIL rand_cmp_flag ins=%h got %b want %b", ins, dz, mz); end
         end
      end
   endtask

   task automatic test_illegal();
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
      int bad;
      start_instr(16'hE000, 1'b0);
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (illegal !== 1'b1 || w !== 1'b0 || strobes !== 13'h0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL trap_hold got %0d bad cycles want 0", bad); end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (w !== 1'b1 || illegal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL trap_reset got w=%b illegal=%b want 1 0", w, illegal);
      end
`else
      logic [15:0] bad_ins [2];
      bad_ins[0] = 16'hE000;
      bad_ins[1] = 16'hC8A5;
      for (int k = 0; k < 2; k++) begin
         run_model(bad_ins[k]);
         checks++;
         if (lat !== 1 || n_illegal !== 1) begin
            errors++;
            $display("[TB] FAIL illegal_pulse ins=%h got lat=%0d pulses=%0d want 1 1", bad_ins[k], lat, n_illegal);
         end
         checks++;
         if (n_write + n_loada + n_loadb + n_loadc + n_loads != 0 || illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_quiet ins=%h got strobes=%0d illegal=%b want 0 0",
                     bad_ins[k], n_write + n_loada + n_loadb + n_loadc + n_loads, illegal);
         end
      end
`endif
   endtask

   initial begin
      $display("[TB] rf_seq_fsm bench start");
      test_reset();
      test_idle_inputs();
      test_mov_imm();
      test_add();
      test_cmp();
      test_mvn_hold();
      test_random();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
